// File: rtl/parity_frame_pkg.sv
// rtl/parity_frame_pkg.sv - shared types and line levels for the parity frame receiver
//
// Purpose: FSM state encoding and serial line levels used by parity_frame_ctrl.
// Ports:   none (package).

package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/parity_acc.sv
// rtl/parity_acc.sv - serial running-parity accumulator
//
// Purpose: XOR-accumulates one serial bit per enabled cycle; clr restarts at 0.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   clr    - restart accumulation (priority over en)
//   en     - fold sbit into the running parity this cycle
//   sbit   - serial bit to accumulate
//   parity - running XOR of all bits folded in since the last clear

module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic sbit,
    output logic parity
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (clr) begin
            parity <= 1'b0;
        end else if (en) begin
            parity <= parity ^ sbit;
        end
    end

endmodule

// File: rtl/parity_frame_ctrl.sv
// rtl/parity_frame_ctrl.sv - framed serial receiver with parity/stop checking and valid/ready output
//
// Purpose: samples x on en strobes through start/data/parity/stop, checks parity
//          and stop bit, and presents each word on a valid/ready handshake.
// Build option: PARITY_FRAME_CTRL_ERR_CNT_EN enables the saturating err_cnt
//          counter; without it err_cnt is tied to 0.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   x          - serial data line (idle high), sampled when en=1
//   en         - bit strobe
//   out_ready  - consumer accepts the presented word
//   out_valid  - word available, held until accepted
//   out_data   - received word, LSB received first
//   parity_err - parity mismatch for the presented word
//   frame_err  - stop bit was 0 for the presented word
//   overrun    - sticky: a frame completed while the previous word was stalled
//   busy       - receiver is inside a frame
//   err_cnt    - saturating count of parity errors (optional)

module parity_frame_ctrl
    import parity_frame_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x,
    input  logic                 en,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    localparam int              CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   perr_r;
    logic                   acc;
    logic                   acc_clr;
    logic                   acc_en;
    logic                   accept;

    // A start bit restarts the parity; only data bits are folded in.
    assign acc_clr = en && (state == IDLE) && (x == START_LEVEL);
    assign acc_en  = en && (state == DATA);

    parity_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .sbit   (x),
        .parity (acc)
    );

    // A new word may be loaded when the slot is empty or being emptied this edge.
    assign accept = !out_valid || out_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr_r     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Handshake runs every cycle; a completion below overrides the drop.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (en) begin
                case (state)
                    IDLE: begin
                        if (x == START_LEVEL) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg <= {x, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= PAR;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    PAR: begin
                        perr_r <= acc ^ x ^ ODD_PARITY;
                        state  <= STOP;
                    end
                    STOP: begin
                        // Back to IDLE unconditionally: a low stop bit is not a start bit.
                        state <= IDLE;
                        if (accept) begin
                            out_valid  <= 1'b1;
                            out_data   <= shreg;
                            parity_err <= perr_r;
                            frame_err  <= ~x;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PARITY_FRAME_CTRL_ERR_CNT_EN
    logic [7:0] err_q;

    // Counts every completed frame with bad parity, dropped frames included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 8'd0;
        end else if (en && (state == STOP) && perr_r && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb/tb_parity_frame_ctrl.sv - self-checking bench for parity_frame_ctrl (even and odd parity instances)

module tb_parity_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x;
    logic       en;
    logic       out_ready;

    logic       ov    [2];
    logic [7:0] od    [2];
    logic       pe    [2];
    logic       fe    [2];
    logic       ovr   [2];
    logic       bsy   [2];
    logic [7:0] ecnt  [2];

    int total = 0;
    int bad   = 0;

    // Frame-level reference model, one slot per instance (index = ODD_PARITY).
    bit       m_valid [2];
    bit [7:0] m_data  [2];
    bit       m_perr  [2];
    bit       m_ferr  [2];
    bit       m_ovr   [2];
    int       m_cnt   [2];

    bit       pend;
    bit [7:0] pend_data;
    bit       pend_par;
    bit       pend_stop;

    always #5 clk = ~clk;

    parity_frame_ctrl #(.DATA_BITS(8), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .x(x), .en(en), .out_ready(out_ready),
        .out_valid(ov[0]), .out_data(od[0]), .parity_err(pe[0]), .frame_err(fe[0]),
        .overrun(ovr[0]), .busy(bsy[0]), .err_cnt(ecnt[0])
    );

    parity_frame_ctrl #(.DATA_BITS(8), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .x(x), .en(en), .out_ready(out_ready),
        .out_valid(ov[1]), .out_data(od[1]), .parity_err(pe[1]), .frame_err(fe[1]),
        .overrun(ovr[1]), .busy(bsy[1]), .err_cnt(ecnt[1])
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_data[i] = 8'h00; m_perr[i] = 1'b0;
            m_ferr[i]  = 1'b0; m_ovr[i]  = 1'b0;  m_cnt[i]  = 0;
        end
        pend = 1'b0;
    endtask

    // One clock: capture inputs as seen at the edge, advance the model, settle.
    task automatic tick();
        bit r, rs, done, bad_par;
        r    = out_ready;
        rs   = rst_n;
        done = pend && en;
        @(posedge clk);
        if (!rs) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (done) begin
                    // Ones over data+parity must be even (i=0) or odd (i=1).
                    bad_par = ((($countones(pend_data) + int'(pend_par)) % 2) != i);
                    if (!m_valid[i] || r) begin
                        m_valid[i] = 1'b1;
                        m_data[i]  = pend_data;
                        m_perr[i]  = bad_par;
                        m_ferr[i]  = !pend_stop;
                    end else begin
                        m_ovr[i] = 1'b1;
                    end
                    if (bad_par && m_cnt[i] < 255) m_cnt[i]++;
                end else if (m_valid[i] && r) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (done) pend = 1'b0;
        end
        #1;
    endtask

    task automatic send_bit(input bit b, input int gap);
        x  = b;
        en = 1'b1;
        tick();
        for (int g = 0; g < gap; g++) begin
            en = 1'b0;
            x  = 1'($urandom);
            tick();
        end
    endtask

    task automatic send_frame(input bit [7:0] d, input bit par, input bit stop, input int gap);
        send_bit(1'b0, gap);
        for (int k = 0; k < 8; k++) send_bit(d[k], gap);
        send_bit(par, gap);
        pend_data = d; pend_par = par; pend_stop = stop; pend = 1'b1;
        send_bit(stop, gap);
        x  = 1'b1;
        en = 1'b1;
    endtask

    task automatic check_inst(input int i, input string tag);
        int exp_cnt;
`ifdef PARITY_FRAME_CTRL_ERR_CNT_EN
        exp_cnt = m_cnt[i];
`else
        exp_cnt = 0;
`endif
        total++;
        assert (ov[i] === m_valid[i]) else begin
            bad++; $error("FAIL %s[%0d] out_valid: got %0b want %0b", tag, i, ov[i], m_valid[i]);
        end
        total++;
        assert (od[i] === m_data[i]) else begin
            bad++; $error("FAIL %s[%0d] out_data: got %02h want %02h", tag, i, od[i], m_data[i]);
        end
        total++;
        assert (pe[i] === m_perr[i]) else begin
            bad++; $error("FAIL %s[%0d] parity_err: got %0b want %0b", tag, i, pe[i], m_perr[i]);
        end
        total++;
        assert (fe[i] === m_ferr[i]) else begin
            bad++; $error("FAIL %s[%0d] frame_err: got %0b want %0b", tag, i, fe[i], m_ferr[i]);
        end
        total++;
        assert (ovr[i] === m_ovr[i]) else begin
            bad++; $error("FAIL %s[%0d] overrun: got %0b want %0b", tag, i, ovr[i], m_ovr[i]);
        end
        total++;
        assert (ecnt[i] === 8'(exp_cnt)) else begin
            bad++; $error("FAIL %s[%0d] err_cnt: got %0d want %0d", tag, i, ecnt[i], exp_cnt);
        end
    endtask

    task automatic check_both(input string tag);
        check_inst(0, tag);
        check_inst(1, tag);
    endtask

    task automatic check_busy(input string tag, input bit want);
        for (int i = 0; i < 2; i++) begin
            total++;
            assert (bsy[i] === want) else begin
                bad++; $error("FAIL %s[%0d] busy: got %0b want %0b", tag, i, bsy[i], want);
            end
        end
    endtask

    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) else begin
            bad++; $error("FAIL %s: got %02h want %02h", tag, got, want);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; x = 1'b1; en = 1'b1; out_ready = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        check_both("reset");
        check_busy("reset", 1'b0);

        // Good frame 0xA5, even parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        check_both("good_a5");
        check_value("good_a5 data", od[0], 8'hA5);
        check_value("good_a5 valid", {7'd0, ov[0]}, 8'd1);
        check_busy("good_a5", 1'b0);
        drain();
        check_both("good_a5 drained");

        // Parity error: 0x07 needs parity 1 for even
        send_frame(8'h07, 1'b0, 1'b1, 0);
        check_both("perr_07");
        check_value("perr_07 perr", {7'd0, pe[0]}, 8'd1);
        drain();

        // Framing error, then a stalled second frame
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        check_both("ferr_3c");
        check_value("ferr_3c ferr", {7'd0, fe[0]}, 8'd1);
        send_frame(8'h55, 1'b0, 1'b1, 0);
        check_both("overrun_55");
        check_value("overrun_55 data held", od[0], 8'h3C);
        check_value("overrun_55 flag", {7'd0, ovr[0]}, 8'd1);
        drain();
        check_both("overrun drained");

        // en strobe every third cycle
        send_frame(8'hF0, 1'b0, 1'b1, 2);
        check_both("gap_f0");
        drain();

        // Reset in the middle of the data bits
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        check_busy("mid_frame", 1'b1);
        rst_n = 1'b0;
        x = 1'b1;
        tick();
        rst_n = 1'b1;
        check_busy("mid_reset", 1'b0);
        check_both("mid_reset");
        send_frame(8'h81, 1'b0, 1'b1, 0);
        check_both("after_reset_81");
        drain();

        // 0x00: parity bit 1 is good for odd, parity bit 0 is bad for odd
        send_frame(8'h00, 1'b1, 1'b1, 0);
        check_both("odd_p1");
        check_value("odd_p1 perr", {7'd0, pe[1]}, 8'd0);
        drain();
        send_frame(8'h00, 1'b0, 1'b1, 0);
        check_both("odd_p0");
        check_value("odd_p0 perr", {7'd0, pe[1]}, 8'd1);
        drain();

        // Back-to-back with ready tied high
        out_ready = 1'b1;
        send_frame(8'h12, 1'b0, 1'b1, 0);
        check_both("b2b_12");
        check_value("b2b_12 data", od[0], 8'h12);
        send_frame(8'h34, 1'b1, 1'b1, 0);
        check_both("b2b_34");
        check_value("b2b_34 data", od[0], 8'h34);
        check_value("b2b overrun", {7'd0, ovr[0]}, 8'd0);
        tick();
        check_both("b2b_idle");
        out_ready = 1'b0;

        // Randomized frames: corrupt parity/stop, random gaps, ready and idle time
        for (int n = 0; n < 40; n++) begin
            bit [7:0] d;
            bit       par;
            bit       stop;
            d    = 8'($urandom);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            out_ready = 1'($urandom_range(0, 1));
            send_frame(d, par, stop, $urandom_range(0, 2));
            check_both("rand");
            for (int k = 0; k < $urandom_range(0, 3); k++) begin
                x = 1'b1;
                en = 1'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            x = 1'b1;
            en = 1'b1;
        end
        check_both("rand_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_frame_ctrl.md
Name: parity_frame_ctrl

Overview:
- Framed serial receiver controller that sequences a running-parity datapath over start/data/parity/stop frames.
- Deserialises DATA_BITS data bits, checks the received parity bit against the accumulated parity, and checks the stop bit.
- Presents each completed word on a valid/ready output handshake.
- Sits between the serial line (already synchronised, one bit per en strobe) and a word consumer.

Parameters:
- DATA_BITS, 8, data bits per frame (2..16).
- ODD_PARITY, 0, 0 = even parity, 1 = odd parity. The expected parity bit makes the count of ones over data plus parity even or odd, respectively.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- x  input  1  serial data line, idle high.
- en  input  1  bit strobe; x is sampled only in cycles with en=1.
- out_ready  input  1  consumer accepts the word.
- out_valid  output  1  word available, held until accepted.
- out_data  output  DATA_BITS  received word, LSB received first.
- parity_err  output  1  parity mismatch for the presented word.
- frame_err  output  1  stop bit was 0 for the presented word.
- overrun  output  1  sticky: a frame completed while out_valid=1 and out_ready=0.
- busy  output  1  high in any state other than IDLE.
- err_cnt  output  8  saturating parity-error count (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE.
  - out_valid, parity_err, frame_err, overrun, busy and err_cnt all 0.
  - out_data=0; shift register and parity accumulator cleared.
  - Reset mid-frame discards the partial frame.
- FSM advances only on cycles with en=1; with en=0 all state holds.
  - IDLE: x=0 -> DATA, bit_cnt=0, acc=0. x=1 -> stay.
  - DATA: shift x in at MSB (shift right); acc ^= x; bit_cnt++. When bit_cnt reaches DATA_BITS-1 -> PAR.
  - PAR: perr_n = (acc ^ x ^ ODD_PARITY) != 0; -> STOP.
  - STOP: ferr_n = ~x; complete frame; -> IDLE. A stop bit of 0 is not re-treated as a start bit in the same cycle.
- Completion, registered at the STOP-sample edge:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: load out_data, parity_err and frame_err; set out_valid=1 on the next cycle. Latency = 1 clk after the stop-bit sample edge.
  - Otherwise: drop the new frame, set overrun=1, and leave the presented word untouched.
- Handshake:
  - out_valid falls on the edge where out_valid and out_ready are both 1, unless a completion reloads it the same edge (back-to-back).
  - out_data, parity_err and frame_err are stable while out_valid=1 and out_ready=0.
- overrun clears only on reset.
- busy = (state != IDLE).
- Width: bit_cnt is clog2(DATA_BITS) bits with no wrap beyond DATA_BITS-1; acc is 1 bit.

Optional Feature:
- Macro PARITY_FRAME_CTRL_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on each completed frame with perr_n=1, including dropped (overrun) frames. It saturates at 255 and is cleared only by reset.
- Undefined: err_cnt is constant 0 and the counter logic is absent.

Decomposition:
- Shared package parity_frame_pkg:
  - state enum {IDLE, DATA, PAR, STOP}.
  - localparams for idle-line level (1) and start level (0).
- Sub-module parity_acc: serial running-parity accumulator with clk, rst_n, clr, en and bit inputs and a parity output. It is instantiated once inside the controller.

Test Plan:
All scenarios use DATA_BITS=8 and ODD_PARITY=0 unless stated, with en=1 every cycle.
- Good frame 0xA5: x = 0, 1,0,1,0,0,1,0,1, 0, 1 -> out_valid=1 one cycle after the stop edge, out_data=8'hA5, parity_err=0, frame_err=0, busy=0 after stop.
- Parity error: frame 0x07 with parity bit 0 (expected 1) -> out_data=8'h07, parity_err=1; err_cnt=1 if the macro is defined.
- Framing error plus stall: frame 0x3C with correct parity and stop=0 -> frame_err=1. Hold out_ready=0 and send a good 0x55 frame -> overrun=1, out_data stays 8'h3C. Assert out_ready -> out_valid=0.
- en gaps and reset: send 0xF0 with en=1 every 3rd cycle -> same result as contiguous. Then assert rst_n=0 mid-DATA -> next edge busy=0, outputs 0, and a following good frame 0x81 is received correctly.
- ODD_PARITY=1: frame 0x00 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.
- Back-to-back: out_ready=1 tied high, two frames 0x12 then 0x34 with no idle gap -> two out_valid pulses carrying 8'h12 then 8'h34, overrun=0.
